// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, memory
// command codes and the legal-address check.
package dmem_pkg;

  typedef logic [1:0] dmem_state_t;
  typedef logic [1:0] mem_op_t;

  localparam dmem_state_t ST_IDLE  = 2'd0;
  localparam dmem_state_t ST_ISSUE = 2'd1;
  localparam dmem_state_t ST_WAIT  = 2'd2;
  localparam dmem_state_t ST_RESP  = 2'd3;

  localparam mem_op_t MEM_OP_NONE = 2'd0;
  localparam mem_op_t MEM_OP_ACT  = 2'd1;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] ALIGN_MASK = 32'(WORD_BYTES - 1);

  // A word access is legal when it is word aligned and lies inside the
  // implemented 2**abits byte window.
  function automatic logic addr_ok(input logic [31:0] a, input int unsigned abits);
    return ((a & ALIGN_MASK) == 32'd0) && ((a >> abits) == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick. The port that did not win last time has
// priority when both request; rr_last starts at 1 so port 0 wins first.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_gnt,
  output logic       o_any
);

  logic r_last;

  // Combinational winner selection from the request pair and last winner.
  always_comb begin
    o_any = |i_req;
    case (i_req)
      2'b01:   o_gnt = 1'b0;
      2'b10:   o_gnt = 1'b1;
      2'b11:   o_gnt = ~r_last;
      default: o_gnt = 1'b0;
    endcase
  end

  // Remember the winner whenever the arbiter actually accepts a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_take) begin
      r_last <= o_gnt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage (port 0)
// and the debug/DMA loader (port 1). One access at a time; legal accesses
// take ISSUE -> WAIT -> RESP, illegal addresses skip straight to RESP.
//
// state | meaning
// IDLE  | no transaction; arbitrate on any request
// ISSUE | memory command on the bus; memory acts at the closing edge
// WAIT  | read data returning from memory; captured at the closing edge
// RESP  | done (and err) pulse to the winning port
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_write,
  output logic [1:0]        mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  dmem_state_t       r_state;
  logic              r_id;
  logic              r_we;
  logic              r_err;

  logic              w_gnt;
  logic              w_any;
  logic              w_take;
  logic              w_sel_we;
  logic [31:0]       w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_ok;
  logic              w_resp;

  assign w_take = (r_state == ST_IDLE) && w_any;

  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .i_req  ({p1_req, p0_req}),
    .i_take (w_take),
    .o_gnt  (w_gnt),
    .o_any  (w_any)
  );

  // Mux the winning port's request fields and check its address.
  always_comb begin
    w_sel_we    = w_gnt ? p1_we    : p0_we;
    w_sel_addr  = w_gnt ? p1_addr  : p0_addr;
    w_sel_wdata = w_gnt ? p1_wdata : p0_wdata;
    w_ok        = addr_ok(w_sel_addr, ADDR_BITS);
  end

  // Transaction FSM plus the registered memory command and read-data ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_id      <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= MEM_OP_NONE;
      mem_read  <= MEM_OP_NONE;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id <= w_gnt;
            r_we <= w_sel_we;
            if (w_ok) begin
              r_err     <= 1'b0;
              mem_addr  <= w_sel_addr;
              mem_wdata <= w_sel_wdata;
              mem_write <= w_sel_we ? MEM_OP_ACT  : MEM_OP_NONE;
              mem_read  <= w_sel_we ? MEM_OP_NONE : MEM_OP_ACT;
              r_state   <= ST_ISSUE;
            end else begin
              // Illegal address: no memory cycle, report straight away.
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          mem_write <= MEM_OP_NONE;
          mem_read  <= MEM_OP_NONE;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!r_we) begin
            if (r_id) p1_rdata <= mem_rdata;
            else      p0_rdata <= mem_rdata;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_resp  = (r_state == ST_RESP);
  assign p0_done = w_resp & ~r_id;
  assign p1_done = w_resp &  r_id;
  assign p0_err  = p0_done & r_err;
  assign p1_err  = p1_done & r_err;
  assign busy    = (r_state != ST_IDLE);

endmodule
